// File: rtl/perf_pkg.sv
// Shared definitions for the performance-counter read path: fixed counter and
// beat widths, the reader FSM encoding and a counter slice helper.
package perf_pkg;

  localparam int CNT_W   = 64;
  localparam int DATA_W  = 32;
  localparam int MAX_CNT = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND_LO = 2'd1,
    ST_SEND_HI = 2'd2
  } state_e;

  // Return counter idx from a bus padded to the maximum supported bank size.
  // The caller zero-extends its narrower bus, so every idx in 0..15 is legal.
  function automatic logic [CNT_W-1:0] counter_slice(
    input logic [MAX_CNT*CNT_W-1:0] bus,
    input logic [3:0]               idx
  );
    logic [9:0] base;
    base = {idx, 6'd0};
    return bus[base +: CNT_W];
  endfunction

endpackage

// File: rtl/perf_count_mux.sv
// Combinational NUM_CNT:1 selector over the 64-bit counter bank with a range
// check on the requested index. Out-of-range requests yield a zero value.
module perf_count_mux
  import perf_pkg::*;
#(
  parameter int NUM_CNT = 4,
  parameter int IDX_W   = 4
) (
  input  logic [NUM_CNT*CNT_W-1:0] count_i,
  input  logic [IDX_W-1:0]         idx_i,
  output logic [CNT_W-1:0]         sel_value_o,
  output logic                     idx_err_o
);

  logic [MAX_CNT*CNT_W-1:0] bus_s;
  logic [3:0]               idx4_s;

  // Pad the bank to the maximum size, range-check the index and select.
  always_comb begin
    bus_s                       = '0;
    bus_s[NUM_CNT*CNT_W-1:0]    = count_i;
    idx4_s                      = 4'(idx_i);
    idx_err_o                   = (32'(idx_i) >= 32'(NUM_CNT));
    if (idx_err_o) begin
      sel_value_o = 64'd0;
    end else begin
      sel_value_o = counter_slice(bus_s, idx4_s);
    end
  end

endmodule

// File: rtl/perf_count_reader.sv
// Reads one 64-bit event counter atomically on request and returns it as two
// 32-bit beats (low word first) on a valid/ready channel, with an optional
// one-cycle clear pulse to the selected counter for read-and-clear.
module perf_count_reader
  import perf_pkg::*;
#(
  parameter int NUM_CNT = 4,
  parameter int IDX_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CNT*CNT_W-1:0] count_in,
  output logic [NUM_CNT-1:0]       cnt_clr,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [IDX_W-1:0]         req_idx,
  input  logic                     req_clear,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_last,
  output logic                     rsp_err
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    snap_q, snap_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_last_q, rsp_last_d;
  logic                rsp_err_q, rsp_err_d;
  logic [NUM_CNT-1:0]  cnt_clr_q, cnt_clr_d;

  logic [CNT_W-1:0]    sel_value_s;
  logic                idx_err_s;
  logic [NUM_CNT-1:0]  clr_onehot_s;

  perf_count_mux #(
    .NUM_CNT (NUM_CNT),
    .IDX_W   (IDX_W)
  ) u_mux (
    .count_i     (count_in),
    .idx_i       (req_idx),
    .sel_value_o (sel_value_s),
    .idx_err_o   (idx_err_s)
  );

  // Decode the requested index into a one-hot clear vector.
  always_comb begin
    clr_onehot_s = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      clr_onehot_s[i] = (32'(req_idx) == 32'(i));
    end
  end

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
    rsp_err_d   = rsp_err_q;
    cnt_clr_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          // Whole 64-bit value is taken in this one cycle, so the high beat
          // can never pair with a low word from a different cycle.
          state_d     = ST_SEND_LO;
          snap_d      = sel_value_s;
          req_ready_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = sel_value_s[DATA_W-1:0];
          rsp_last_d  = 1'b0;
          rsp_err_d   = idx_err_s;
          if (req_clear && !idx_err_s) begin
            cnt_clr_d = clr_onehot_s;
          end else begin
            cnt_clr_d = '0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND_LO: begin
        if (rsp_ready) begin
          state_d    = ST_SEND_HI;
          rsp_data_d = snap_q[CNT_W-1:DATA_W];
          rsp_last_d = 1'b1;
        end else begin
          state_d = ST_SEND_LO;
        end
      end
      ST_SEND_HI: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_data_d  = 32'd0;
          rsp_last_d  = 1'b0;
          rsp_err_d   = 1'b0;
        end else begin
          state_d = ST_SEND_HI;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        snap_d      = 64'd0;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_data_d  = 32'd0;
        rsp_last_d  = 1'b0;
        rsp_err_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset discards any in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      snap_q      <= 64'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      cnt_clr_q   <= '0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      rsp_err_q   <= rsp_err_d;
      cnt_clr_q   <= cnt_clr_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_err   = rsp_err_q;
  assign cnt_clr   = cnt_clr_q;

endmodule

// File: tb/tb_perf_count_reader.sv
// Randomized scoreboard bench for perf_count_reader. The bench owns a bank of
// counters; at each accepted request the expected two beats are queued from
// the counter value of that cycle, and a monitor checks every handshake.
module tb_perf_count_reader;

  localparam int NUM = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        err;
  } beat_t;

  logic             clk;
  logic             rst_n;
  logic [NUM*64-1:0] count_in;
  logic [NUM-1:0]   cnt_clr;
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_idx;
  logic             req_clear;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic             rsp_last;
  logic             rsp_err;

  // Bench-side counter bank
  logic [63:0]      cnt [NUM];
  logic [NUM-1:0]   inc_en;
  logic             load_en;
  logic [1:0]       load_idx;
  logic [63:0]      load_val;

  int total = 0;
  int bad   = 0;
  int hs_cnt = 0;
  beat_t sb_q[$];
  logic [NUM-1:0] exp_clr = '0;
  logic [31:0] last_lo, last_hi;
  logic        last_err;
  bit          hold_v = 1'b0;
  logic [31:0] hold_d;
  logic        hold_l, hold_e;

  perf_count_reader #(.NUM_CNT(NUM), .IDX_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .count_in  (count_in),
    .cnt_clr   (cnt_clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_idx   (req_idx),
    .req_clear (req_clear),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counter bank: synchronous clear from the DUT wins over load and increment
  always @(posedge clk) begin
    for (int i = 0; i < NUM; i++) begin
      if (!rst_n || cnt_clr[i]) cnt[i] <= 64'd0;
      else if (load_en && load_idx == 2'(i)) cnt[i] <= load_val;
      else if (inc_en[i]) cnt[i] <= cnt[i] + 64'd1;
    end
  end

  always_comb begin
    count_in = '0;
    for (int i = 0; i < NUM; i++) count_in[i*64 +: 64] = cnt[i];
  end

  // Request observer: checks the clear pulse and queues expected beats
  always @(negedge clk) begin
    logic [63:0] v;
    bit oor;
    if (!rst_n) begin
      exp_clr = '0;
    end else begin
      check("cnt_clr", 64'(cnt_clr), 64'(exp_clr));
      exp_clr = '0;
      if (req_valid && req_ready) begin
        oor = (req_idx >= 4'(NUM));
        v = 64'd0;
        if (!oor) v = cnt[req_idx[1:0]];
        sb_q.push_back('{data: v[31:0],  last: 1'b0, err: oor});
        sb_q.push_back('{data: v[63:32], last: 1'b1, err: oor});
        if (req_clear && !oor) exp_clr = NUM'(1) << req_idx;
      end
    end
  end

  // Response monitor: pops the scoreboard on every handshake
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      sb_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("bp_stable", {rsp_valid, rsp_last, rsp_err, rsp_data}, {1'b1, hold_l, hold_e, hold_d});
      end
      if (rsp_valid) check("ready_while_busy", 64'(req_ready), 64'd0);
      if (rsp_valid && rsp_ready) begin
        hs_cnt++;
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat: got data %h with no beat expected", rsp_data);
        end else begin
          e = sb_q.pop_front();
          check("beat", {rsp_last, rsp_err, rsp_data}, {e.last, e.err, e.data});
          if (rsp_last) begin last_hi = rsp_data; last_err = rsp_err; end
          else last_lo = rsp_data;
        end
      end
      hold_v = rsp_valid && !rsp_ready;
      hold_d = rsp_data; hold_l = rsp_last; hold_e = rsp_err;
    end
  end

  task automatic load(input int idx, input logic [63:0] val);
    load_en = 1'b1; load_idx = 2'(idx); load_val = val;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 40) begin @(posedge clk); #1; n++; end
    if (!req_ready) check("ready_timeout", 64'(req_ready), 64'd1);
  endtask

  task automatic do_read(input int idx, input bit clr, input int bp_lo, input int bp_hi);
    wait_ready();
    req_valid = 1'b1; req_idx = 4'(idx); req_clear = clr;
    @(posedge clk); #1;
    req_valid = 1'b0; req_clear = 1'b0;
    rsp_ready = 1'b0;
    repeat (bp_lo) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    repeat (bp_hi) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("sb_drained", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    rst_n = 1'b0; req_valid = 1'b0; req_idx = 4'd0; req_clear = 1'b0;
    rsp_ready = 1'b1; inc_en = '0; load_en = 1'b0; load_idx = 2'd0; load_val = 64'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_outputs", {rsp_valid, rsp_last, rsp_err, rsp_data}, 64'd0);
    check("rst_clr", 64'(cnt_clr), 64'd0);

    // Basic read
    load(2, 64'h0000_0001_0000_0005);
    do_read(2, 1'b0, 0, 0);
    check("basic", {last_err, last_hi, last_lo}, {1'b0, 32'h1, 32'h5});

    // Lower-word wrap while incrementing every cycle
    load(0, 64'h0000_0000_FFFF_FFFE);
    inc_en[0] = 1'b1;
    @(posedge clk); #1;
    do_read(0, 1'b0, 0, 0);
    inc_en[0] = 1'b0;
    check("wrap", {last_hi, last_lo}, {32'h0, 32'hFFFF_FFFF});

    // Read-and-clear, then re-read
    load(1, 64'h2A);
    do_read(1, 1'b1, 0, 0);
    check("rdclr", {last_hi, last_lo}, {32'h0, 32'h2A});
    do_read(1, 1'b0, 0, 0);
    check("rdclr_again", {last_hi, last_lo}, 64'd0);

    // Backpressure on both beats
    h0 = hs_cnt;
    do_read(2, 1'b0, 5, 3);
    check("bp_handshakes", 64'(hs_cnt - h0), 64'd2);
    check("bp_data", {last_hi, last_lo}, {32'h1, 32'h5});

    // Out-of-range index with clear requested
    do_read(7, 1'b1, 0, 0);
    check("oor", {last_err, last_hi, last_lo}, {1'b1, 64'd0});

    // Asynchronous reset during the high beat
    load(3, 64'h1234_5678_9ABC_DEF0);
    wait_ready();
    req_valid = 1'b1; req_idx = 4'd3; req_clear = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_clear = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(rsp_valid), 64'd0);
    check("async_rst_ready", 64'(req_ready), 64'd1);
    check("async_rst_clr", 64'(cnt_clr), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1; rsp_ready = 1'b1;
    check("post_rst", {req_ready, rsp_valid}, {1'b1, 1'b0});
    inc_en[3] = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    do_read(3, 1'b0, 0, 0);
    inc_en[3] = 1'b0;

    // Randomized reads, clears, loads and backpressure; back-to-back when bp=0
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0)
        load($urandom_range(0, NUM-1),
             {$urandom, ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7))) : $urandom});
      inc_en = NUM'($urandom);
      do_read($urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    inc_en = '0;
    repeat (3) begin @(posedge clk); #1; end
    check("final_idle", {req_ready, rsp_valid}, {1'b1, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
